// File: rtl/chroni_text_fetch.sv
// chroni_text_fetch: per-scanline text/font fetch engine writing palette-indexed pixels into a line buffer half
module chroni_text_fetch #(
    parameter int COLS           = 80,
    parameter int FONT_ROWS_LOG2 = 3,
    parameter int VRAM_LAT       = 2,
    parameter int ADDR_W         = 17,
    parameter int LB_AW          = 11
) (
    input  logic                      sys_clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      buffer_sel,
    input  logic                      attr_mode,
    input  logic [ADDR_W-1:0]         text_base,
    input  logic [ADDR_W-1:0]         attr_base,
    input  logic [ADDR_W-1:0]         font_base,
    input  logic [FONT_ROWS_LOG2-1:0] font_row,
    input  logic [7:0]                fg_color,
    input  logic [7:0]                bg_color,
    output logic                      vram_rd_en,
    output logic [ADDR_W-1:0]         vram_addr,
    input  logic [7:0]                vram_rd_data,
    output logic                      lb_wr_en,
    output logic [LB_AW-1:0]          lb_wr_addr,
    output logic [7:0]                lb_wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);
    typedef enum logic [2:0] {
        IDLE, CODE_REQ, CODE_WAIT, ATTR_REQ, ATTR_WAIT, FONT_REQ, FONT_WAIT, EMIT
    } state_t;

    state_t                    state;
    logic [7:0]                col, code, attr_byte, shift, fg_q, bg_q, wait_cnt;
    logic [2:0]                pix;
    logic                      buf_q, mode_q;
    logic [ADDR_W-1:0]         text_base_q, attr_base_q, font_base_q, font_addr;
    logic [FONT_ROWS_LOG2-1:0] row_q;
    logic [7:0]                fg_eff, bg_eff, code_src;
    logic                      lat_hit;
    logic [LB_AW-1:0]          lb_base;

    // the code byte is used straight off the bus when it is captured, otherwise from its register
    assign code_src  = state == CODE_WAIT ? vram_rd_data : code;
    assign font_addr = font_base_q + (ADDR_W'(code_src) << FONT_ROWS_LOG2) + ADDR_W'(row_q);
    assign fg_eff    = mode_q ? {fg_q[7:4], attr_byte[3:0]} : fg_q;
    assign bg_eff    = mode_q ? {bg_q[7:4], attr_byte[7:4]} : bg_q;
    assign lat_hit   = wait_cnt == 8'(VRAM_LAT - 1);
    assign lb_base   = (buf_q ? LB_AW'(COLS * 8) : '0) + LB_AW'({col, 3'b000});

    // scanline sequencer: fetch code/attr/font per column, then emit 8 pixels
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            vram_rd_en  <= 1'b0;
            vram_addr   <= '0;
            lb_wr_en    <= 1'b0;
            lb_wr_addr  <= '0;
            lb_wr_data  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            col         <= '0;
            code        <= '0;
            attr_byte   <= '0;
            shift       <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            wait_cnt    <= '0;
            pix         <= '0;
            buf_q       <= 1'b0;
            mode_q      <= 1'b0;
            text_base_q <= '0;
            attr_base_q <= '0;
            font_base_q <= '0;
            row_q       <= '0;
        end else begin
            vram_rd_en <= 1'b0;
            lb_wr_en   <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                if (start && state != IDLE) overrun <= 1'b1;
                case (state)
                    IDLE: if (start) begin
                        buf_q       <= buffer_sel;
                        mode_q      <= attr_mode;
                        text_base_q <= text_base;
                        attr_base_q <= attr_base;
                        font_base_q <= font_base;
                        row_q       <= font_row;
                        fg_q        <= fg_color;
                        bg_q        <= bg_color;
                        col         <= '0;
                        busy        <= 1'b1;
                        vram_rd_en  <= 1'b1;
                        vram_addr   <= text_base;
                        state       <= CODE_REQ;
                    end
                    CODE_REQ, ATTR_REQ, FONT_REQ: begin
                        wait_cnt <= '0;
                        state    <= state == CODE_REQ ? CODE_WAIT : state == ATTR_REQ ? ATTR_WAIT : FONT_WAIT;
                    end
                    CODE_WAIT: begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (lat_hit) begin
                            code       <= vram_rd_data;
                            vram_rd_en <= 1'b1;
                            vram_addr  <= mode_q ? attr_base_q + ADDR_W'(col) : font_addr;
                            state      <= mode_q ? ATTR_REQ : FONT_REQ;
                        end
                    end
                    ATTR_WAIT: begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (lat_hit) begin
                            attr_byte  <= vram_rd_data;
                            vram_rd_en <= 1'b1;
                            vram_addr  <= font_addr;
                            state      <= FONT_REQ;
                        end
                    end
                    FONT_WAIT: begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (lat_hit) begin
                            shift      <= {vram_rd_data[6:0], 1'b0};
                            lb_wr_en   <= 1'b1;
                            lb_wr_addr <= lb_base;
                            lb_wr_data <= vram_rd_data[7] ? fg_eff : bg_eff;
                            pix        <= '0;
                            state      <= EMIT;
                        end
                    end
                    EMIT: if (pix != 3'd7) begin
                        shift      <= {shift[6:0], 1'b0};
                        lb_wr_en   <= 1'b1;
                        lb_wr_addr <= lb_wr_addr + LB_AW'(1);
                        lb_wr_data <= shift[7] ? fg_eff : bg_eff;
                        pix        <= pix + 3'd1;
                    end else if (col == 8'(COLS - 1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        col        <= col + 8'd1;
                        vram_rd_en <= 1'b1;
                        vram_addr  <= text_base_q + ADDR_W'(col) + ADDR_W'(1);
                        state      <= CODE_REQ;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/chroni_text_fetch.md
Name: chroni_text_fetch

Overview:
Parametrised per-scanline text/font fetch engine for the Chroni video subsystem. It is the generalised successor of the fixed 80-column, 8-row, monochrome character generator. Per scanline it reads character codes, and optionally attribute bytes, from VRAM, then fetches the font row for each character. Each font row is expanded into 8 palette-indexed pixels written one per cycle into one half of the double-buffered line buffer. Column count, font height, VRAM latency and address widths are parameters; an attribute-colour mode is added.

Parameters:
COLS, 80, characters per scanline (1..255)
FONT_ROWS_LOG2, 3, log2 of font rows per glyph (3 = 8 rows, 4 = 16 rows)
VRAM_LAT, 2, cycles from vram_rd_en to valid vram_rd_data (>=1)
ADDR_W, 17, VRAM address width
LB_AW, 11, line buffer address width; 2*COLS*8 must be <= 2^LB_AW

Ports:
sys_clk  in  1  single clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: render one scanline
abort  in  1  one-cycle pulse: cancel the scanline in progress (frame start / mode change)
buffer_sel  in  1  line buffer half: 0 = base 0, 1 = base COLS*8
attr_mode  in  1  0 = fixed fg/bg colours, 1 = per-character attribute byte
text_base  in  ADDR_W  VRAM address of column 0 code
attr_base  in  ADDR_W  VRAM address of column 0 attribute
font_base  in  ADDR_W  VRAM address of glyph 0, row 0
font_row  in  FONT_ROWS_LOG2  glyph row for this scanline
fg_color  in  8  foreground index (mode 0); bits[7:4] are the palette page in mode 1
bg_color  in  8  background index (mode 0); bits[7:4] are the palette page in mode 1
vram_rd_en  out  1  VRAM read request
vram_addr  out  ADDR_W  VRAM read address
vram_rd_data  in  8  VRAM read data
lb_wr_en  out  1  line buffer write strobe
lb_wr_addr  out  LB_AW  line buffer pixel address
lb_wr_data  out  8  palette index
busy  out  1  scanline in progress
done  out  1  one-cycle pulse: scanline complete
overrun  out  1  one-cycle pulse: start received while busy

Behaviour:
- Reset (async, reset_n=0): state IDLE; every output 0; column counter 0.
- IDLE: start=1 latches all configuration inputs, sets busy=1 next cycle, column=0, enters CODE_REQ. Inputs are ignored after latch until the next accepted start.
- Fetch sub-sequence, used for code, attribute and font:
  - REQ state drives vram_rd_en=1 with the address for exactly one cycle.
  - Data is captured VRAM_LAT cycles later.
  - The next state begins the cycle after capture. Cost per fetch: VRAM_LAT+1 cycles.
- Addresses, all modulo 2^ADDR_W:
  - code = text_base + col
  - attr = attr_base + col
  - font = font_base + (code << FONT_ROWS_LOG2) + font_row
- States: IDLE -> CODE_REQ -> CODE_WAIT -> [ATTR_REQ -> ATTR_WAIT, only when attr_mode=1] -> FONT_REQ -> FONT_WAIT -> EMIT (8 cycles) -> CODE_REQ for the next column, or DONE.
- EMIT: one pixel per cycle, MSB first. For bit b (7..0) at pixel p (0..7):
  - lb_wr_addr = (buffer_sel ? COLS*8 : 0) + col*8 + p
  - lb_wr_data: set bit -> fg, clear bit -> bg
  - Mode 0: fg = fg_color, bg = bg_color.
  - Mode 1: fg = {fg_color[7:4], attr[3:0]}, bg = {bg_color[7:4], attr[7:4]}.
- Cycles per character: mode 0 = 2*(VRAM_LAT+1)+8; mode 1 = 3*(VRAM_LAT+1)+8.
- DONE: entered after the last pixel of column COLS-1. That cycle: done=1, busy=0, state returns to IDLE. A start on the cycle after done is accepted normally.
- start while busy: ignored; overrun=1 for one cycle; scanline continues unaffected.
- abort: on the next cycle, state=IDLE, busy=0, vram_rd_en=0, lb_wr_en=0, no done pulse. Any in-flight VRAM data is discarded. abort and start in the same cycle: abort wins and start is dropped. abort in IDLE has no effect.
- vram_rd_en and lb_wr_en are never high in the same cycle.

Test Plan:
- Mode 0 timing: COLS=4, VRAM_LAT=2, start at cycle 0, code 0x41 at text_base=0x100, font byte 0xA5. Required: vram_rd_en at cycle 1, address 0x100. Font read at cycle 4, address font_base+0x208 when font_row=0. lb_wr_en cycles 7..14, data fg,bg,fg,bg,bg,fg,bg,fg. done at cycle 57, busy high cycles 1..56.
- Mode 1 attribute: attr=0x3C, fg_color=0x50, bg_color=0x60, font byte 0xF0. Required: pixels 0x5C x4, then 0x63 x4. Char period 17 cycles at VRAM_LAT=2.
- Buffer select / 16-row font: COLS=80, buffer_sel=1, FONT_ROWS_LOG2=4, font_row=15, code 0xFF. Required: first write address 640, last address 1279. Font address = font_base+0xFFF.
- Address wrap: text_base=0x1FFFF, ADDR_W=17. Required: column 1 code read at address 0x00000.
- Abort mid-scanline: abort during EMIT of column 2. Required: no writes or reads from the next cycle, busy=0, no done. A new start then restarts at column 0.
- Overrun and simultaneous events: start while busy gives overrun pulse and unchanged timing. abort+start in the same cycle gives IDLE and no busy. reset_n low mid-line clears all outputs immediately.
